// File: rtl/fifo_drain.sv
// Read-side drain controller for an 8-bit synchronous FIFO: issues reads, absorbs the
// one-cycle read latency in a 2-entry buffer and presents words on a valid/ready stream.
module fifo_drain #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 fifo_empty,
    input  logic                 fifo_underflow,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 rd_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] drain_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e               state_q, state_d;
    logic [1:0]           occ_q, occ_d;
    logic                 inflight_q;
    logic [WIDTH-1:0]     head_q, head_d;
    logic [WIDTH-1:0]     tail_q, tail_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 pop;
    logic                 capture;
    logic                 space_ok;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = head_q;
    assign busy      = (state_q != StIdle);
    assign drain_cnt = cnt_q;
    assign err       = err_q;

    assign pop     = out_valid & out_ready;
    assign capture = inflight_q;

    // In-flight reads reserve a slot, so the buffer can never overflow on capture.
    assign space_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_en    = (state_q == StRun) & ~fifo_empty & space_ok;

    always_comb begin
        occ_d  = occ_q + {1'b0, capture} - {1'b0, pop};
        head_d = head_q;
        tail_d = tail_q;
        if (pop) begin
            head_d = tail_q;
        end
        if (capture) begin
            if (occ_q == {1'b0, pop}) begin
                head_d = fifo_rdata;
            end else begin
                tail_d = fifo_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en) state_d = StRun;
            StRun:  if (!en) state_d = StStop;
            StStop: begin
                // occ_d==0 also implies nothing was in flight, since a capture adds a word.
                if (en) begin
                    state_d = StRun;
                end else if (occ_d == 2'd0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    assign err_d = err_q | fifo_underflow | (rd_en & fifo_empty);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural FIFO model, stream monitor and
// immediate-assertion checks against hand-derived expectations.
module tb_fifo_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       fifo_underflow = 1'b0;
    logic       out_ready = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'd0;

    logic        rd_en, out_valid, busy, err;
    logic [7:0]  out_data;
    logic [15:0] drain_cnt;

    logic        rd_en4, out_valid4, busy4, err4;
    logic [7:0]  out_data4;
    logic [3:0]  drain_cnt4;

    fifo_drain #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rdata(fifo_rdata), .rd_en(rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
        .drain_cnt(drain_cnt), .err(err)
    );

    // Narrow-counter copy sees identical inputs, so it tracks the main DUT word for word.
    fifo_drain #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .fifo_rdata(fifo_rdata), .rd_en(rd_en4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4),
        .drain_cnt(drain_cnt4), .err(err4)
    );

    // FIFO model: one-cycle read latency, one push per cycle on request.
    logic [7:0] fq[$];
    logic       push_en = 1'b0;
    logic [7:0] push_val = 8'd0;
    logic       clr_en = 1'b0;
    int         uf_cnt = 0;
    int         fifo_level = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            if (fq.size() != 0) fifo_rdata <= fq.pop_front();
            else uf_cnt++;
        end
        if (clr_en) fq.delete();
        if (push_en) fq.push_back(push_val);
        fifo_empty <= (fq.size() == 0);
        fifo_level <= fq.size();
    end

    // Stream monitor, sampled mid-cycle.
    logic [7:0] got[$];
    int rd_total = 0, rd_rises = 0, pop_rises = 0, empty_viol = 0;
    logic rd_prev = 1'b0, pop_prev = 1'b0;

    always begin
        @(negedge clk);
        #2;
        if (rd_en) rd_total++;
        if (rd_en && !rd_prev) rd_rises++;
        if (out_valid && out_ready && !pop_prev) pop_rises++;
        if (out_valid && out_ready) got.push_back(out_data);
        if (rd_en && fifo_empty) empty_viol++;
        rd_prev  = rd_en;
        pop_prev = out_valid && out_ready;
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [7:0] v);
        push_val = v;
        push_en  = 1'b1;
        tick(1);
        push_en  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    task automatic check_words(input string tag, input int base, input int first, input int n);
        logic [31:0] obs;
        check({tag, "_count"}, got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            obs = (base + i < got.size()) ? 32'(got[base + i]) : 32'hffff_ffff;
            check(tag, obs, first + i);
        end
    endtask

    int base, rd_b, rr_b, pr_b, ev_b, uf_b;

    initial begin
        // Reset with enable high and 5 words waiting.
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(8'(10 + i));
        tick(2);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", drain_cnt, 0);
        check("rst_err", err, 0);
        base = got.size();
        rst = 1'b1;
        #1;
        check("rel_rd_en0", rd_en, 0);
        tick(1);
        check("rel_rd_en1", rd_en, 1);
        check("rel_busy", busy, 1);
        check("rel_valid1", out_valid, 0);
        tick(1);
        check("rel_valid2", out_valid, 0);
        tick(1);
        check("rel_valid3", out_valid, 1);
        check("rel_data3", out_data, 10);
        tick(10);
        check_words("rel_words", base, 10, 5);
        check("rel_cnt", drain_cnt, 5);

        // Streaming: 50..59 back to back.
        en = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) push_word(8'(50 + i));
        base = got.size(); rd_b = rd_total; rr_b = rd_rises; pr_b = pop_rises;
        en = 1'b1;
        tick(20);
        check("str_rd_total", rd_total - rd_b, 10);
        check("str_rd_runs", rd_rises - rr_b, 1);
        check("str_pop_runs", pop_rises - pr_b, 1);
        check_words("str_words", base, 50, 10);
        check("str_cnt", drain_cnt, 10);
        check("str_err", err, 0);

        // Backpressure: 16 words, 8 stalled cycles.
        en = 1'b0; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) push_word(8'(100 + i));
        base = got.size(); rd_b = rd_total; uf_b = uf_cnt;
        en = 1'b1;
        tick(4);
        check("bp_data_a", out_data, 100);
        tick(4);
        check("bp_stall_rds", rd_total - rd_b, 2);
        check("bp_valid", out_valid, 1);
        check("bp_data_b", out_data, 100);
        check("bp_rd_low", rd_en, 0);
        out_ready = 1'b1;
        #1;
        check("bp_rd_resume", rd_en, 1);
        tick(30);
        check_words("bp_words", base, 100, 16);
        check("bp_rd_total", rd_total - rd_b, 16);
        check("bp_underflow", uf_cnt - uf_b, 0);
        check("bp_cnt", drain_cnt, 16);

        // Empty boundary: one word, gap, three words.
        do_reset();
        base = got.size(); ev_b = empty_viol;
        push_word(8'd200);
        tick(8);
        check("emp_first", got.size() - base, 1);
        check("emp_valid_gap", out_valid, 0);
        check("emp_rd_gap", rd_en, 0);
        tick(4);
        push_word(8'd201); push_word(8'd202); push_word(8'd203);
        tick(10);
        check_words("emp_words", base, 200, 4);
        check("emp_cnt", drain_cnt, 4);
        check("emp_viol", empty_viol - ev_b, 0);

        // Stop with one word buffered and one in flight.
        en = 1'b0; out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) push_word(8'(30 + i));
        base = got.size(); rd_b = rd_total;
        en = 1'b1;
        tick(2);
        en = 1'b0;
        tick(1);
        check("stop_busy", busy, 1);
        check("stop_rds", rd_total - rd_b, 2);
        tick(3);
        check("stop_rd_low", rd_en, 0);
        check("stop_valid", out_valid, 1);
        check("stop_data0", out_data, 30);
        out_ready = 1'b1;
        tick(1);
        check("stop_busy_last", busy, 1);
        check("stop_data1", out_data, 31);
        tick(1);
        check("stop_busy_fall", busy, 0);
        check("stop_valid_fall", out_valid, 0);
        tick(3);
        check_words("stop_words", base, 30, 2);
        check("stop_rd_total", rd_total - rd_b, 2);
        check("stop_fifo_left", fifo_level, 4);
        clr_en = 1'b1;
        tick(1);
        clr_en = 1'b0;

        // Counter wrap on the 4-bit instance.
        do_reset();
        for (int i = 0; i < 17; i++) push_word(8'(i));
        base = got.size();
        en = 1'b1;
        tick(30);
        check_words("wrap_words", base, 0, 17);
        check("wrap_cnt16", drain_cnt, 17);
        check("wrap_cnt4", drain_cnt4, 1);

        // Sticky error from underflow.
        check("err_pre", err, 0);
        fifo_underflow = 1'b1;
        tick(1);
        fifo_underflow = 1'b0;
        check("err_set", err, 1);
        tick(5);
        check("err_hold", err, 1);
        do_reset();
        check("err_clear", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
